load_align_unit: RTL and testbench

//  Load-side counterpart of the store aligner: accepts a load request (addr[1:0], size, signedness),

---
 rtl/load_align_unit_if.sv | 47 ++++
 rtl/load_align_unit.sv | 158 +++++++++++++++
 tb/tb_load_align_unit.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/load_align_unit_if.sv
// Bundles the load-request, data-memory read and writeback sides of the load aligner.
// LoadFault exists only when LOAD_FAULT_EN is defined. "master" is the aligner's view.
`default_nettype none

interface load_align_unit_if;
  logic        ReqValid;
  logic        ReqReady;
  logic [1:0]  ReqAddr;
  logic [1:0]  ReqType;
  logic        ReqUnsigned;
  logic        MemReadEn;
  logic [3:0]  MemByteSel;
  logic        MemRespValid;
  logic [31:0] MemData;
  logic        LoadValid;
  logic        LoadReady;
  logic [31:0] LoadData;
`ifdef LOAD_FAULT_EN
  logic        LoadFault;
`endif

  modport master (
    input  ReqValid, ReqAddr, ReqType, ReqUnsigned,
    output ReqReady,
    output MemReadEn, MemByteSel,
    input  MemRespValid, MemData,
    output LoadValid, LoadData,
`ifdef LOAD_FAULT_EN
    output LoadFault,
`endif
    input  LoadReady
  );

  modport slave (
    output ReqValid, ReqAddr, ReqType, ReqUnsigned,
    input  ReqReady,
    input  MemReadEn, MemByteSel,
    output MemRespValid, MemData,
    input  LoadValid, LoadData,
`ifdef LOAD_FAULT_EN
    input  LoadFault,
`endif
    output LoadReady
  );
endinterface

`default_nettype wire

// File: rtl/load_align_unit.sv
// Load aligner: single-beat memory read, byte/half/word extraction with sign/zero extension.
// Optional LOAD_FAULT_EN adds LoadFault for illegal requests and response timeouts.
`default_nettype none

module load_align_unit #(
  parameter int TIMEOUT   = 16,
  parameter int TIMEOUT_W = 5
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  load_align_unit_if.master  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [1:0]           r_addr;
  logic [1:0]           r_type;
  logic                 r_uns;
  logic [31:0]          r_data;
  logic [TIMEOUT_W-1:0] r_cnt;

  logic                 w_legal;
  logic                 w_timeout;
  logic                 w_capture;
  logic                 w_tmo_hit;
  logic [3:0]           w_sel;
  logic [7:0]           w_byte;
  logic [15:0]          w_half;
  logic [31:0]          w_ext;
  logic                 w_req_ready;
  logic                 w_rd_en;
  logic [3:0]           w_byte_sel;
  logic                 w_load_valid;

  // Byte: any offset; half: even offset; word: offset 0; type 3 never legal.
  always_comb begin
    w_legal = 1'b0;
    case (bus.ReqType)
      2'd0:    w_legal = 1'b1;
      2'd1:    w_legal = ~bus.ReqAddr[0];
      2'd2:    w_legal = (bus.ReqAddr == 2'd0);
      default: w_legal = 1'b0;
    endcase
  end

  assign w_timeout = (TIMEOUT != 0) && (r_cnt == TIMEOUT_W'(TIMEOUT - 1));
  assign w_capture = ((r_state == S_REQ) || (r_state == S_WAIT)) && bus.MemRespValid;
  assign w_tmo_hit = (r_state == S_WAIT) && !bus.MemRespValid && w_timeout;

  always_comb begin
    w_sel = 4'b1111;
    case (r_type)
      2'd0:    w_sel = 4'b0001 << r_addr;
      2'd1:    w_sel = r_addr[1] ? 4'b1100 : 4'b0011;
      default: w_sel = 4'b1111;
    endcase
  end

  always_comb begin
    w_byte = bus.MemData[7:0];
    case (r_addr)
      2'd0:    w_byte = bus.MemData[7:0];
      2'd1:    w_byte = bus.MemData[15:8];
      2'd2:    w_byte = bus.MemData[23:16];
      default: w_byte = bus.MemData[31:24];
    endcase
    w_half = r_addr[1] ? bus.MemData[31:16] : bus.MemData[15:0];
    w_ext  = bus.MemData;
    case (r_type)
      2'd0:    w_ext = r_uns ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
      2'd1:    w_ext = r_uns ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_ext = bus.MemData;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_req_ready  = 1'b0;
    w_rd_en      = 1'b0;
    w_byte_sel   = 4'b0000;
    w_load_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_req_ready = 1'b1;
        if (bus.ReqValid) w_next = w_legal ? S_REQ : S_RESP;
      end
      S_REQ: begin
        w_rd_en    = 1'b1;
        w_byte_sel = w_sel;
        w_next     = bus.MemRespValid ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        w_byte_sel = w_sel;
        if (bus.MemRespValid || w_timeout) w_next = S_RESP;
      end
      S_RESP: begin
        w_load_valid = 1'b1;
        if (bus.LoadReady) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Request fields are latched so the extract path never depends on live request inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= 2'd0;
      r_type <= 2'd0;
      r_uns  <= 1'b0;
      r_data <= 32'h0;
      r_cnt  <= '0;
    end else begin
      if ((r_state == S_IDLE) && bus.ReqValid) begin
        r_addr <= bus.ReqAddr;
        r_type <= bus.ReqType;
        r_uns  <= bus.ReqUnsigned;
        if (!w_legal) r_data <= 32'h0;
      end
      if (w_capture)      r_data <= w_ext;
      else if (w_tmo_hit) r_data <= 32'h0;
      r_cnt <= ((r_state == S_WAIT) && (w_next == S_WAIT)) ? r_cnt + 1'b1 : '0;
    end
  end

`ifdef LOAD_FAULT_EN
  logic r_fault;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                               r_fault <= 1'b0;
    else if ((r_state == S_IDLE) && bus.ReqValid && !w_legal) r_fault <= 1'b1;
    else if (w_tmo_hit)                                       r_fault <= 1'b1;
    else if ((r_state == S_RESP) && bus.LoadReady)            r_fault <= 1'b0;
  end

  assign bus.LoadFault = r_fault;
`endif

  assign bus.ReqReady   = w_req_ready;
  assign bus.MemReadEn  = w_rd_en;
  assign bus.MemByteSel = w_byte_sel;
  assign bus.LoadValid  = w_load_valid;
  assign bus.LoadData   = r_data;

endmodule

`default_nettype wire

// File: tb/tb_load_align_unit.sv
// Scoreboard bench for load_align_unit: expected loads queued at request, checked at writeback.
`default_nettype none

module tb_load_align_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  load_align_unit_if bus_if();

  load_align_unit #(.TIMEOUT(16), .TIMEOUT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  int n_err = 0;
  int n_chk = 0;
  int cyc   = 0;
  always @(posedge clk) cyc++;

  typedef struct packed {
    logic [31:0] data;
    logic        fault;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_legal(input logic [1:0] a, input logic [1:0] t);
    if (t == 2'd0) return 1'b1;
    if (t == 2'd1) return (a == 2'd0) || (a == 2'd2);
    if (t == 2'd2) return a == 2'd0;
    return 1'b0;
  endfunction

  function automatic logic [3:0] exp_sel(input logic [1:0] a, input logic [1:0] t);
    logic [3:0] one;
    logic [3:0] two;
    one = 4'b0001;
    two = 4'b0011;
    if (t == 2'd0) return one << a;
    if (t == 2'd1) return two << a;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] exp_data(input logic [1:0] a, input logic [1:0] t,
                                           input logic u, input logic [31:0] md);
    logic [31:0] sh;
    sh = md >> (8 * a);
    if (t == 2'd0) return u ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
    if (t == 2'd1) return u ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
    return md;
  endfunction

  // dly < 0 means memory never answers.
  task automatic run_load(input logic [1:0] a, input logic [1:0] t, input logic u,
                          input int dly, input logic [31:0] md, input int hold);
    int   c0;
    int   lat_exp;
    bit   legal;
    bit   got;
    exp_t e;
    exp_t p;
    legal   = is_legal(a, t);
    e.data  = (legal && dly >= 0) ? exp_data(a, t, u, md) : 32'h0;
    e.fault = !(legal && dly >= 0);
    sb.push_back(e);
    lat_exp = !legal ? 1 : (dly < 0 ? 2 + 16 : 2 + dly);

    chk("req_ready_idle", 32'(bus_if.ReqReady), 32'd1);
    bus_if.ReqValid    = 1'b1;
    bus_if.ReqAddr     = a;
    bus_if.ReqType     = t;
    bus_if.ReqUnsigned = u;
    c0 = cyc;
    @(negedge clk);
    bus_if.ReqValid    = 1'b0;
    bus_if.ReqAddr     = 2'(~a);
    bus_if.ReqUnsigned = ~u;
    if (legal) begin
      chk("rd_en", 32'(bus_if.MemReadEn), 32'd1);
      chk("byte_sel", 32'(bus_if.MemByteSel), 32'(exp_sel(a, t)));
      if (dly >= 0) begin
        repeat (dly) @(negedge clk);
        if (dly > 0) begin
          chk("rd_en_wait", 32'(bus_if.MemReadEn), 32'd0);
          chk("sel_held", 32'(bus_if.MemByteSel), 32'(exp_sel(a, t)));
        end
        bus_if.MemRespValid = 1'b1;
        bus_if.MemData      = md;
      end
    end else begin
      chk("no_rd_en", 32'(bus_if.MemReadEn), 32'd0);
    end

    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus_if.LoadValid) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
      bus_if.MemRespValid = 1'b0;
      bus_if.MemData      = $urandom;
    end
    bus_if.MemRespValid = 1'b0;
    chk("load_valid_seen", 32'(got), 32'd1);
    chk("latency", 32'(cyc - c0), 32'(lat_exp));

    for (int i = 0; i < hold; i++) begin
      chk("hold_valid", 32'(bus_if.LoadValid), 32'd1);
      chk("hold_req_ready", 32'(bus_if.ReqReady), 32'd0);
      chk("hold_data", bus_if.LoadData, e.data);
      bus_if.MemData = $urandom;
      @(negedge clk);
    end

    bus_if.LoadReady = 1'b1;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      p = sb.pop_front();
      chk("load_data", bus_if.LoadData, p.data);
`ifdef LOAD_FAULT_EN
      chk("load_fault", 32'(bus_if.LoadFault), 32'(p.fault));
`endif
    end
    @(negedge clk);
    bus_if.LoadReady = 1'b0;
    chk("valid_drop", 32'(bus_if.LoadValid), 32'd0);
    chk("req_ready_back", 32'(bus_if.ReqReady), 32'd1);
  endtask

  initial begin
    bus_if.ReqValid     = 1'b0;
    bus_if.ReqAddr      = 2'd0;
    bus_if.ReqType      = 2'd0;
    bus_if.ReqUnsigned  = 1'b0;
    bus_if.MemRespValid = 1'b0;
    bus_if.MemData      = 32'h0;
    bus_if.LoadReady    = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_load_valid", 32'(bus_if.LoadValid), 32'd0);
    chk("rst_rd_en", 32'(bus_if.MemReadEn), 32'd0);
    chk("rst_sel", 32'(bus_if.MemByteSel), 32'd0);
    chk("rst_data", bus_if.LoadData, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    run_load(2'd3, 2'd0, 1'b0, 0, 32'h8012_3456, 0);   // LB off 3
    run_load(2'd2, 2'd1, 1'b1, 3, 32'hBEEF_0000, 0);   // LHU off 2, late
    run_load(2'd1, 2'd1, 1'b0, 0, 32'h1111_1111, 0);   // LH off 1, illegal
    run_load(2'd0, 2'd2, 1'b0, 0, 32'hCAFE_F00D, 5);   // LW, slow consumer
    run_load(2'd0, 2'd2, 1'b0, -1, 32'h0, 0);          // LW, timeout
    run_load(2'd1, 2'd0, 1'b1, 1, 32'h0000_A500, 1);   // LBU off 1
    run_load(2'd0, 2'd1, 1'b0, 2, 32'h1234_8001, 0);   // LH off 0, negative
    run_load(2'd2, 2'd3, 1'b0, 0, 32'h5555_5555, 0);   // type 3
    run_load(2'd2, 2'd2, 1'b1, 0, 32'h5555_5555, 0);   // LW off 2
    run_load(2'd0, 2'd2, 1'b1, 0, 32'h8000_0001, 0);   // LW ignores unsigned
    for (int k = 0; k < 8; k++) begin
      run_load(2'($urandom_range(0, 3)), 2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 4)), $urandom, int'($urandom_range(0, 2)));
    end

    // Reset while waiting, then a stray response must not resurrect the load.
    bus_if.ReqValid = 1'b1;
    bus_if.ReqAddr  = 2'd0;
    bus_if.ReqType  = 2'd2;
    @(negedge clk);
    bus_if.ReqValid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_ready", 32'(bus_if.ReqReady), 32'd1);
    chk("arst_rd_en", 32'(bus_if.MemReadEn), 32'd0);
    chk("arst_sel", 32'(bus_if.MemByteSel), 32'd0);
    chk("arst_valid", 32'(bus_if.LoadValid), 32'd0);
    chk("arst_data", bus_if.LoadData, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bus_if.MemRespValid = 1'b1;
    bus_if.MemData      = 32'hFFFF_FFFF;
    @(negedge clk);
    bus_if.MemRespValid = 1'b0;
    repeat (2) @(negedge clk);
    chk("stray_valid", 32'(bus_if.LoadValid), 32'd0);
    chk("stray_data", bus_if.LoadData, 32'h0);
    chk("stray_ready", 32'(bus_if.ReqReady), 32'd1);
`ifdef LOAD_FAULT_EN
    chk("stray_fault", 32'(bus_if.LoadFault), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

`default_nettype wire
